// File: rtl/led_fc_pkg.sv
// Shared types and constants for the LED band FC writer and its LAT command decoder.
package led_fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fc_state_e;

    // Default SCLK edge counts (while LAT is high) that encode the driver commands.
    localparam int FCWRTEN_CNT_DEF = 15;
    localparam int WRTFC_CNT_DEF   = 5;

    // Band address width; never narrower than one bit, even for a single band.
    function automatic int addr_width(input int n_bands);
        return (n_bands > 1) ? $clog2(n_bands) : 1;
    endfunction

endpackage

// File: rtl/led_band_fc_writer_if.sv
// HPS register-side bus of the FC writer: band word writes plus the sticky error flags.
interface led_band_fc_writer_if import led_fc_pkg::*; #(
    parameter int N_BANDS  = 1,
    parameter int FC_WIDTH = 48
);
    localparam int ADDR_W = addr_width(N_BANDS);

    logic [ADDR_W-1:0]   hps_fc_addr;
    logic [FC_WIDTH-1:0] hps_fc_data;
    logic                hps_fc_write;
    logic                hps_err_clr;
    logic                err_short;
    logic                err_long;

    modport master (
        output hps_fc_addr, hps_fc_data, hps_fc_write, hps_err_clr,
        input  err_short, err_long
    );

    modport slave (
        input  hps_fc_addr, hps_fc_data, hps_fc_write, hps_err_clr,
        output err_short, err_long
    );

endinterface

// File: rtl/led_lat_cmd_decoder.sv
// Decodes LAT-length driver commands: counts SCLK rising edges while LAT is high and
// pulses fcwrten / wrtfc for the one cycle after LAT falls.
module led_lat_cmd_decoder import led_fc_pkg::*; #(
    parameter int FCWRTEN_CNT = FCWRTEN_CNT_DEF,
    parameter int WRTFC_CNT   = WRTFC_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic SCLK,
    input  logic LAT,
    output logic sclk_rise,
    output logic data_rise,
    output logic fcwrten,
    output logic wrtfc
);

    logic       sclk_reg;
    logic [3:0] lat_cnt_reg;

    // Delay SCLK by one clk for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) sclk_reg <= 1'b0;
        else     sclk_reg <= SCLK;
    end

    assign sclk_rise = SCLK & ~sclk_reg;
    // Edges clocked while LAT is high belong to a command, not to FC data.
    assign data_rise = sclk_rise & ~LAT;

    // Saturating count of rising edges during LAT high; cleared whenever LAT is low.
    always_ff @(posedge clk) begin
        if (rst || !LAT)                          lat_cnt_reg <= 4'd0;
        else if (sclk_rise && lat_cnt_reg != 4'hF) lat_cnt_reg <= lat_cnt_reg + 4'd1;
    end

    // The count survives into the first LAT-low cycle, giving a one-cycle pulse.
    assign fcwrten = ~LAT & (lat_cnt_reg == 4'(FCWRTEN_CNT));
    assign wrtfc   = ~LAT & (lat_cnt_reg == 4'(WRTFC_CNT));

endmodule

// File: rtl/led_band_fc_writer.sv
// Multi-band FC register writer: holds one FC word per band and shifts it MSB-first on
// that band's SOUT bit, CHAIN_LEN times, between FCWRTEN and WRTFC.
// Build option LED_FC_SHADOW_EN: separate shadow bank copied to active on FCWRTEN;
// when undefined, HPS writes go straight to the active words.
module led_band_fc_writer import led_fc_pkg::*; #(
    parameter int N_BANDS     = 1,
    parameter int FC_WIDTH    = 48,
    parameter int CHAIN_LEN   = 1,
    parameter int FCWRTEN_CNT = FCWRTEN_CNT_DEF,
    parameter int WRTFC_CNT   = WRTFC_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCLK,
    input  logic               LAT,
    output logic               en,
    output logic [N_BANDS-1:0] SOUT,
    led_band_fc_writer_if.slave hps
);

    localparam int ADDR_W = addr_width(N_BANDS);
    localparam int IDX_W  = $clog2(FC_WIDTH);
    localparam int DRV_W  = ($clog2(CHAIN_LEN + 1) > 1) ? $clog2(CHAIN_LEN + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(FC_WIDTH - 1);
    localparam logic [DRV_W-1:0] DRV_LAST = DRV_W'(CHAIN_LEN - 1);

    logic sclk_rise, data_rise, fcwrten, wrtfc;

    fc_state_e        state_reg, state_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic [DRV_W-1:0] drv_cnt_reg, drv_cnt_next;
    logic             en_reg;
    logic             err_short_reg, err_long_reg;
    logic             set_short, set_long;

    led_lat_cmd_decoder #(
        .FCWRTEN_CNT (FCWRTEN_CNT),
        .WRTFC_CNT   (WRTFC_CNT)
    ) u_cmd (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .LAT       (LAT),
        .sclk_rise (sclk_rise),
        .data_rise (data_rise),
        .fcwrten   (fcwrten),
        .wrtfc     (wrtfc)
    );

    // Next-state logic: command pulses take priority over a coincident data edge.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        drv_cnt_next = drv_cnt_reg;
        set_short    = 1'b0;
        set_long     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (fcwrten) begin
                    state_next   = SHIFT;
                    bit_idx_next = IDX_MSB;
                    drv_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (wrtfc) begin
                    set_short  = 1'b1;
                    state_next = IDLE;
                end else if (fcwrten) begin
                    set_short    = 1'b1;
                    bit_idx_next = IDX_MSB;
                    drv_cnt_next = '0;
                end else if (data_rise) begin
                    if (bit_idx_reg == '0) begin
                        bit_idx_next = IDX_MSB;
                        drv_cnt_next = drv_cnt_reg + DRV_W'(1);
                        if (drv_cnt_reg == DRV_LAST) state_next = DONE;
                    end else begin
                        bit_idx_next = bit_idx_reg - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (wrtfc) begin
                    state_next = IDLE;
                end else if (fcwrten) begin
                    state_next   = SHIFT;
                    bit_idx_next = IDX_MSB;
                    drv_cnt_next = '0;
                end else if (data_rise) begin
                    set_long = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and the registered en flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_idx_reg <= IDX_MSB;
            drv_cnt_reg <= '0;
            en_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            drv_cnt_reg <= drv_cnt_next;
            en_reg      <= (state_next == IDLE);
        end
    end

    // Sticky protocol error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
        end else begin
            err_short_reg <= set_short | (err_short_reg & ~hps.hps_err_clr);
            err_long_reg  <= set_long  | (err_long_reg  & ~hps.hps_err_clr);
        end
    end

    assign en            = en_reg;
    assign hps.err_short = err_short_reg;
    assign hps.err_long  = err_long_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BANDS; gi++) begin : g_band
            logic [FC_WIDTH-1:0] active_reg;
            logic                hit;

            // Addresses at or beyond N_BANDS match no band and are dropped.
            assign hit = hps.hps_fc_write && (hps.hps_fc_addr == ADDR_W'(gi));

`ifdef LED_FC_SHADOW_EN
            logic [FC_WIDTH-1:0] shadow_reg;

            // Shadow word takes HPS writes at any time.
            always_ff @(posedge clk) begin
                if (rst)      shadow_reg <= '0;
                else if (hit) shadow_reg <= hps.hps_fc_data;
            end

            // Active word snapshots the shadow on every FCWRTEN, so a write in the
            // same cycle only reaches the shadow.
            always_ff @(posedge clk) begin
                if (rst)          active_reg <= '0;
                else if (fcwrten) active_reg <= shadow_reg;
            end
`else
            // Single bank: writes land in the live word and show on the next bit.
            always_ff @(posedge clk) begin
                if (rst)      active_reg <= '0;
                else if (hit) active_reg <= hps.hps_fc_data;
            end
`endif

            // MSB is presented while idle so it is valid before the first edge.
            assign SOUT[gi] = (state_reg == SHIFT) ? active_reg[bit_idx_reg] :
                              (state_reg == IDLE)  ? active_reg[FC_WIDTH-1]  : 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_led_band_fc_writer.sv
// Randomised self-checking bench for led_band_fc_writer (3 bands, 2-driver chain).
// The reference model tracks frames as "edges shifted since FCWRTEN" and follows
// LED_FC_SHADOW_EN the same way the design does.
module tb_led_band_fc_writer;

    localparam int NB    = 3;
    localparam int FW    = 48;
    localparam int CL    = 2;
    localparam int TOTAL = FW * CL;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          SCLK = 1'b0;
    logic          LAT  = 1'b0;
    logic          en;
    logic [NB-1:0] SOUT;

    led_band_fc_writer_if #(.N_BANDS(NB), .FC_WIDTH(FW)) hps_bus ();

    led_band_fc_writer #(
        .N_BANDS     (NB),
        .FC_WIDTH    (FW),
        .CHAIN_LEN   (CL),
        .FCWRTEN_CNT (15),
        .WRTFC_CNT   (5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .SCLK (SCLK),
        .LAT  (LAT),
        .en   (en),
        .SOUT (SOUT),
        .hps  (hps_bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [FW-1:0] m_shadow [NB];
    logic [FW-1:0] m_active [NB];
    bit            m_busy;
    int            m_edges;
    bit            m_err_short;
    bit            m_err_long;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int b = 0; b < NB; b++) begin
            m_shadow[b] = '0;
            m_active[b] = '0;
        end
        m_busy = 0; m_edges = 0; m_err_short = 0; m_err_long = 0;
    endtask

    task automatic m_write(input int addr, input logic [FW-1:0] data);
        if (addr < NB) begin
`ifdef LED_FC_SHADOW_EN
            m_shadow[addr] = data;
`else
            m_active[addr] = data;
`endif
        end
    endtask

    task automatic m_fcwrten();
        if (m_busy && m_edges < TOTAL) m_err_short = 1;
`ifdef LED_FC_SHADOW_EN
        for (int b = 0; b < NB; b++) m_active[b] = m_shadow[b];
`endif
        m_busy = 1; m_edges = 0;
    endtask

    task automatic m_wrtfc();
        if (m_busy) begin
            if (m_edges < TOTAL) m_err_short = 1;
            m_busy = 0;
        end
    endtask

    task automatic m_edge();
        if (m_busy) begin
            if (m_edges >= TOTAL) m_err_long = 1;
            else m_edges++;
        end
    endtask

    function automatic logic [NB-1:0] exp_sout();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) begin
            if (!m_busy)              v[b] = m_active[b][FW-1];
            else if (m_edges < TOTAL) v[b] = m_active[b][FW-1 - (m_edges % FW)];
            else                      v[b] = 1'b0;
        end
        return v;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".en"}, 64'(en), 64'(!m_busy));
        chk({where, ".sout"}, 64'(SOUT), 64'(exp_sout()));
        chk({where, ".err_short"}, 64'(hps_bus.err_short), 64'(m_err_short));
        chk({where, ".err_long"}, 64'(hps_bus.err_long), 64'(m_err_long));
    endtask

    function automatic logic [FW-1:0] rand_word();
        return {16'($urandom), $urandom};
    endfunction

    task automatic sclk_pulse();
        SCLK = 1'b1; tick();
        SCLK = 1'b0; tick();
    endtask

    task automatic hps_write(input int addr, input logic [FW-1:0] data);
        hps_bus.hps_fc_addr  = 2'(addr);
        hps_bus.hps_fc_data  = data;
        hps_bus.hps_fc_write = 1'b1;
        tick();
        hps_bus.hps_fc_write = 1'b0;
        m_write(addr, data);
    endtask

    // LAT-length command; optional HPS write and error clear land in the pulse cycle.
    task automatic lat_cmd(input int n, input bit do_wr, input int addr,
                           input logic [FW-1:0] data, input bit do_clr);
        LAT = 1'b1;
        repeat (n) sclk_pulse();
        LAT = 1'b0;
        hps_bus.hps_fc_addr  = 2'(addr);
        hps_bus.hps_fc_data  = data;
        hps_bus.hps_fc_write = do_wr;
        hps_bus.hps_err_clr  = do_clr;
        tick();
        hps_bus.hps_fc_write = 1'b0;
        hps_bus.hps_err_clr  = 1'b0;
        if (do_clr) begin m_err_short = 0; m_err_long = 0; end
        if (n == 15) m_fcwrten();
        if (n == 5)  m_wrtfc();
        if (do_wr)   m_write(addr, data);
    endtask

    // One frame: FCWRTEN, n_edges data edges (optional HPS write after edge wr_at),
    // then WRTFC or leave it open for the next frame's FCWRTEN.
    task automatic run_frame(input int n_edges, input int wr_at, input bit end_wrtfc);
        lat_cmd(15, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), rand_word(), 1'b0);
        check_all("fcwrten");
        for (int k = 0; k < n_edges; k++) begin
            sclk_pulse();
            m_edge();
            check_all("shift");
            if (k == wr_at) begin
                hps_write($urandom_range(0, NB - 1), rand_word());
                check_all("midwr");
            end
        end
        if (end_wrtfc) begin
            lat_cmd(5, 1'b0, 0, '0, ($urandom_range(0, 3) == 0));
            check_all("wrtfc");
        end
    endtask

    initial begin
        hps_bus.hps_fc_addr  = '0;
        hps_bus.hps_fc_data  = '0;
        hps_bus.hps_fc_write = 1'b0;
        hps_bus.hps_err_clr  = 1'b0;
        m_reset();
        repeat (3) tick();
        check_all("reset");
        rst = 1'b0;
        tick();

        // Directed: known word on band 0, full-length frame, no errors.
        hps_write(0, 48'hA5A5_0000_FFFF);
        hps_write(1, 48'h1234_5678_9ABC);
        hps_write(2, 48'hFEDC_BA98_7654);
        hps_write(3, 48'hFFFF_FFFF_FFFF);
        check_all("idle");
        run_frame(TOTAL, -1, 1'b1);

        // Directed: short frame, then clear.
        run_frame(20, -1, 1'b1);
        chk("short_flag", 64'(hps_bus.err_short), 64'd1);
        lat_cmd(0, 1'b0, 0, '0, 1'b1);
        check_all("clr");

        // Directed: one edge too many, with a mid-frame write at bit 10.
        run_frame(TOTAL + 1, 10, 1'b1);
        chk("long_flag", 64'(hps_bus.err_long), 64'd1);
        run_frame(5, -1, 1'b0);
        run_frame(TOTAL, -1, 1'b1);

        // Randomised frames, with stray edges while idle between some of them.
        for (int f = 0; f < 30; f++) begin
            int sel, n, wr_at;
            sel   = $urandom_range(0, 3);
            n     = (sel < 2) ? TOTAL : (sel == 2) ? $urandom_range(1, TOTAL - 1)
                                                   : TOTAL + $urandom_range(1, 3);
            wr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            run_frame(n, wr_at, ($urandom_range(0, 3) != 0));
            if (!m_busy && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    sclk_pulse();
                    m_edge();
                    check_all("idle_edge");
                end
            end
        end

        // Reset in the middle of a frame clears state, flags and all FC words.
        run_frame(20, -1, 1'b1);
        run_frame(30, -1, 1'b0);
        rst = 1'b1;
        tick();
        m_reset();
        check_all("midrst");
        rst = 1'b0;
        tick();
        run_frame(3, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_band_fc_writer.md
# led_band_fc_writer

Parametrised function-control (FC) register writer for the LED band drivers.
- Holds one FC word per band and decodes the driver LAT-length commands (FCWRTEN, WRTFC) from the shared LAT/SCLK lines.
- Serialises each band's FC word MSB-first onto its own SOUT, repeated for every driver in the daisy chain.
- Sits between the HPS register interface and the band output mux; en tells the sync module when SOUT owns the lines.
- New over the single-band writer: N bands, configurable chain length, shadow buffering, sticky protocol-error flags.

## Interface
- N_BANDS, 1: independent bands, one SOUT bit each
- FC_WIDTH, 48: FC word width per driver
- CHAIN_LEN, 1: daisy-chained drivers per band; the FC word is shifted CHAIN_LEN times
- FCWRTEN_CNT, 15: SCLK rising edges during LAT high that encode FCWRTEN
- WRTFC_CNT, 5: SCLK rising edges during LAT high that encode WRTFC
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- SCLK  in  1  driver shift clock, already synchronous to clk
- LAT  in  1  driver latch line, already synchronous to clk
- en  out  1  high = idle (SOUT not owning lines); low from FCWRTEN until WRTFC
- SOUT  out  N_BANDS  serial FC data, bit b drives band b
- hps_fc_addr  in  ADDR_W  band select; ADDR_W = max(1, $clog2(N_BANDS))
- hps_fc_data  in  FC_WIDTH  FC word
- hps_fc_write  in  1  one-cycle write strobe
- hps_err_clr  in  1  clears both error flags
- err_short  out  1  sticky: WRTFC or FCWRTEN arrived before all bits were shifted
- err_long  out  1  sticky: SCLK edge arrived after all bits were shifted

## Operation
- SCLK rising edge = SCLK & ~SCLK registered.
- lat_cnt (4 bits, saturating at 15) counts rising edges while LAT is high. It clears on every clk cycle with LAT low.
- FCWRTEN pulse = ~LAT & lat_cnt==FCWRTEN_CNT. WRTFC pulse = ~LAT & lat_cnt==WRTFC_CNT. Both last one cycle after LAT falls.
- HPS write: shadow[hps_fc_addr] <= hps_fc_data. Addresses >= N_BANDS are ignored.
- States: IDLE, SHIFT, DONE.
  - IDLE, FCWRTEN: active <= shadow (all bands); bit_idx <= FC_WIDTH-1; drv_cnt <= 0; go to SHIFT.
  - SHIFT, rising edge: if bit_idx==0, set bit_idx <= FC_WIDTH-1 and drv_cnt++; otherwise bit_idx--. After the edge that ends driver CHAIN_LEN-1, go to DONE.
  - SHIFT, WRTFC: err_short <= 1; go to IDLE.
  - SHIFT, FCWRTEN: err_short <= 1; reload from shadow and restart SHIFT.
  - DONE, rising edge: err_long <= 1; stay in DONE.
  - DONE, WRTFC: go to IDLE.
  - DONE, FCWRTEN: restart SHIFT with no error.
  - IDLE: WRTFC and rising edges are ignored.
- en = 1 in IDLE, 0 in SHIFT and DONE. en is registered and follows the state.
- SOUT[b]:
  - SHIFT: active[b][bit_idx].
  - IDLE: active[b][FC_WIDTH-1], so the MSB is valid before the first edge.
  - DONE: 0.
- hps_err_clr clears both flags. If a set and a clear happen in the same cycle, set wins.
- rst during any state returns all state to reset values. Shadow and active words are also cleared.

## Timing
- Reset values:
  - en=1, SOUT=0, err_short=0, err_long=0
  - state IDLE, lat_cnt=0
  - bit_idx=FC_WIDTH-1, drv_cnt=0
  - shadow and active all 0
- Edge detection adds 1 clk; state and bit_idx update on the clk after SCLK is sampled high.
- FCWRTEN cycle N → state SHIFT and en=0 at N+1. SOUT shows the reloaded MSB at N+1.
- A rising edge detected at cycle M → next bit on SOUT at M+1.
- The sync module must issue exactly FC_WIDTH*CHAIN_LEN SCLK rising edges between FCWRTEN and WRTFC.
- An HPS write in the same cycle as FCWRTEN lands in shadow only; active takes the previous shadow contents.
- Counter widths:
  - bit_idx: $clog2(FC_WIDTH)
  - drv_cnt: max(1, $clog2(CHAIN_LEN+1))

## Configuration
- LED_FC_SHADOW_EN defined: shadow and active banks are separate, with copy on FCWRTEN as above.
- LED_FC_SHADOW_EN undefined:
  - No shadow bank; HPS writes go straight to active, even during SHIFT, and take effect on the next bit.
  - FCWRTEN does not copy.
  - This is the legacy behaviour and uses less area.

## Structure
- Package led_fc_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - default FCWRTEN_CNT and WRTFC_CNT constants
  - a function computing ADDR_W
- Sub-module led_lat_cmd_decoder holds the SCLK edge detector, lat_cnt, and the FCWRTEN/WRTFC pulse outputs. The sequence keyers reuse it.

## Test plan
- N_BANDS=1, CHAIN_LEN=1: write 48'hA5A5_0000_FFFF, LAT high for 15 edges, then 48 edges, then LAT high for 5 edges → SOUT sequence MSB-first equals the word; en is low from FCWRTEN+1 until WRTFC+1; no error flags.
- N_BANDS=4, CHAIN_LEN=3, distinct words per band → each SOUT[b] emits its word three times (144 bits); bands are independent.
- WRTFC after 20 edges → err_short=1, state IDLE, en=1. hps_err_clr → err_short=0.
- 49 edges before WRTFC → err_long=1 and SOUT=0 after bit 48.
- LED_FC_SHADOW_EN defined: HPS write at bit 10 of SHIFT → remaining bits unchanged, and the new word appears on the next FCWRTEN. Undefined: bits from 11 onward reflect the new word.
- rst asserted mid-SHIFT → next cycle en=1, SOUT=0, state IDLE, all FC words 0.
